// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit for the HI/LO path: Booth signed multiply,
// shift-add unsigned multiply, and restoring divide on magnitudes. The unit
// takes WIDTH iterations plus one finish cycle per operation.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_next;
    logic             load, step, finish;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] shreg, mcand, a_lat;
    logic             qbit, is_div, is_unsigned, neg_q, neg_r, b_zero;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   mx, dx, sum, sh, acc_step;
    logic [WIDTH-1:0] shreg_step, hi_res, lo_res;
    logic             qbit_step, ge;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (abort) state_next = IDLE;
                     else if (count == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    load   = start;
            RUN:     step   = !abort;
            FINISH:  finish = !abort;
            default: ;
        endcase
    end

    // Operand sign handling for signed divide
    always_comb begin
        a_neg = (op == 2'b10) && a[WIDTH-1];
        b_neg = (op == 2'b10) && b[WIDTH-1];
    end

    // One iteration of the selected algorithm
    always_comb begin
        mx         = is_unsigned ? {1'b0, mcand} : {mcand[WIDTH-1], mcand};
        dx         = {1'b0, mcand};
        sh         = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        ge         = (sh >= dx);
        sum        = acc;
        acc_step   = acc;
        shreg_step = shreg;
        qbit_step  = qbit;
        if (is_div) begin
            acc_step   = ge ? (sh - dx) : sh;
            shreg_step = {shreg[WIDTH-2:0], ge};
        end else if (is_unsigned) begin
            if (shreg[0]) sum = acc + mx;
            acc_step   = {1'b0, sum[WIDTH:1]};
            shreg_step = {sum[0], shreg[WIDTH-1:1]};
        end else begin
            case ({shreg[0], qbit})
                2'b01:   sum = acc + mx;
                2'b10:   sum = acc - mx;
                default: sum = acc;
            endcase
            acc_step   = {sum[WIDTH], sum[WIDTH:1]};
            shreg_step = {sum[0], shreg[WIDTH-1:1]};
            qbit_step  = shreg[0];
        end
    end

    // Final result selection including divide sign fix-up
    always_comb begin
        hi_res = acc[WIDTH-1:0];
        lo_res = shreg;
        if (is_div) begin
            if (b_zero) begin
                hi_res = a_lat;
                lo_res = '1;
            end else begin
                hi_res = neg_r ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
                lo_res = neg_q ? (~shreg + WIDTH'(1)) : shreg;
            end
        end
    end

    // Handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= finish;
        end
    end

    // Iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            acc         <= '0;
            shreg       <= '0;
            mcand       <= '0;
            a_lat       <= '0;
            qbit        <= 1'b0;
            is_div      <= 1'b0;
            is_unsigned <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
        end else if (load) begin
            count       <= CW'(WIDTH);
            acc         <= '0;
            qbit        <= 1'b0;
            a_lat       <= a;
            is_div      <= op[1];
            is_unsigned <= op[0];
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            b_zero      <= (b == '0);
            if (op[1]) begin
                shreg <= a_neg ? (~a + WIDTH'(1)) : a;
                mcand <= b_neg ? (~b + WIDTH'(1)) : b;
            end else begin
                shreg <= b;
                mcand <= a;
            end
        end else if (step) begin
            count <= count - CW'(1);
            acc   <= acc_step;
            shreg <= shreg_step;
            qbit  <= qbit_step;
        end
    end

    // Result registers: written only on finish or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (load) begin
            div_zero <= 1'b0;
        end else if (finish) begin
            hi       <= hi_res;
            lo       <= lo_res;
            div_zero <= is_div && b_zero;
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq at WIDTH=32 and WIDTH=8.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        rst, abort;
    logic        start, busy, done, div_zero;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        start8, busy8, done8, div_zero8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int passed = 0;
    int total  = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    always #5 clk = ~clk;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    mult_div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .abort(abort),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request; returns #1 after the accept edge with operands scrambled
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 200);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz);
        issue(o, x, y);
        wait_done(tag, 33);
        check({tag, "_hi"}, 64'(hi), 64'(ehi));
        check({tag, "_lo"}, 64'(lo), 64'(elo));
        check({tag, "_dz"}, 64'(div_zero), 64'(edz));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo,
                        input logic edz);
        int n = 0;
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done8 && n < 100);
        check({tag, "_lat"}, 64'(n), 64'd9);
        check({tag, "_hi"}, 64'(hi8), 64'(ehi));
        check({tag, "_lo"}, 64'(lo8), 64'(elo));
        check({tag, "_dz"}, 64'(div_zero8), 64'(edz));
    endtask

    task automatic count_no_done(input string tag, input int cycles);
        int pulses = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);

        // Back-to-back arithmetic cases, each accepted in the previous done cycle
        run32("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run32("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        run32("mult_m1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        run32("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run32("divu", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        run32("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run32("divu_zero", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // done is a single pulse; div_zero holds until the next accept
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("dz_hold", 64'(div_zero), 64'd1);
        issue(MULTU, 32'd3, 32'd5);
        check("dz_clear", 64'(div_zero), 64'd0);
        check("busy_run", 64'(busy), 64'd1);
        wait_done("multu_15", 33);
        check("multu_15_lo", 64'(lo), 64'd15);

        // start while busy is ignored
        issue(MULT, 32'd2, 32'd3);
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start", 27);
        check("busy_start_lo", 64'(lo), 64'd6);
        check("busy_start_hi", 64'(hi), 64'd0);

        // abort in RUN: no done, previous result kept
        @(posedge clk); #1;
        issue(MULT, 32'd9, 32'd9);
        repeat (9) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        count_no_done("abort_no_done", 40);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd6);

        // abort in IDLE does not block a start, then back-to-back MULT 6*7
        abort = 1'b1;
        issue(MULTU, 32'd3, 32'd5);
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd1);
        wait_done("idle_abort", 33);
        check("idle_abort_lo", 64'(lo), 64'd15);
        run32("mult_42", MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // reset in the middle of RUN
        @(posedge clk); #1;
        issue(MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        count_no_done("mid_rst_no_done", 40);

        // narrow instance
        run8("w8_mult", MULT, 8'hFD, 8'h07, 8'hFF, 8'hEB, 1'b0);
        run8("w8_div", DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0);
        run8("w8_multu", MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
        run8("w8_divu", DIVU, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0);
        run8("w8_ovf", DIV, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
        run8("w8_dz", DIVU, 8'h09, 8'h00, 8'h09, 8'hFF, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Parametrised iterative multiply/divide unit for the datapath HI/LO path. It supports signed and unsigned multiply, and signed and unsigned divide, at configurable operand width. A start/busy/done handshake, an abort input and a divide-by-zero flag are provided. The control FSM issues one operation at a time and reads hi/lo after done.

Parameters:
WIDTH, 32, operand width in bits; legal range 4..64. Result is 2*WIDTH bits, split across hi and lo.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand or dividend; latched when start is accepted
b  input  WIDTH  multiplier or divisor; latched when start is accepted
abort  input  1  cancels the operation in progress
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; hi/lo are valid from this cycle
div_zero  output  1  set with done when a DIV/DIVU had b==0
hi  output  WIDTH  MULT: product upper half; DIV: remainder
lo  output  WIDTH  MULT: product lower half; DIV: quotient

Behaviour:
- Reset (sync, highest priority, legal in any state):
  - state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0.
  - Iteration counter and internal registers are cleared.
- States:
  - IDLE: start=1 at edge E0 accepts the request. a, b and op are latched, div_zero is cleared, and the counter is set to WIDTH. Go to RUN.
  - RUN: one iteration per edge, on edges E1..E_WIDTH; busy=1. After E_WIDTH, go to FINISH.
  - FINISH: at edge E_WIDTH+1, hi/lo (and div_zero when applicable) are written, done=1, busy=0. Go to IDLE.
- Latency:
  - Exactly WIDTH+1 cycles from the accept edge to done, for all ops including divide-by-zero.
  - The design has no early termination.
- done: high for exactly one cycle; 0 otherwise.
- Back-to-back: start high in the done cycle is accepted, because the FSM is IDLE.
- start while busy: ignored, with no queueing.
- Operand inputs: changes to a/b/op after acceptance have no effect.
- abort:
  - In RUN or FINISH: next edge goes to IDLE, busy=0, no done pulse; hi/lo/div_zero keep their prior values.
  - In IDLE: no effect, and start in the same cycle is still accepted.
- Arithmetic, MULT/MULTU:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT uses two's-complement operands (radix-2 Booth); MULTU uses zero-extended operands.
  - No overflow condition exists.
- Arithmetic, DIV/DIVU:
  - Restoring or non-restoring division on magnitudes; lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; the remainder takes the sign of the dividend. Sign fix-up is done in FINISH.
  - Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0, div_zero=0.
- Divide by zero (b==0, DIV or DIVU):
  - div_zero=1, lo = all ones, hi = a, with full latency.
  - div_zero stays high until the next accepted start or rst.
- hi/lo change only in the FINISH cycle or on rst.

Test Plan:
- Reset 5 cycles into RUN of a MULT -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> done exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT on the same operands -> hi=0x00000000, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> after 33 cycles done=1, div_zero=1, lo=0xFFFFFFFF, hi=5. The next accepted start clears div_zero.
- abort at RUN cycle 10 -> no done, hi/lo hold the previous result. Then start in the done cycle of a following op (MULT 6*7) -> accepted; second done 33 cycles later with lo=42, hi=0.
- Repeat one MULT and one DIV case with WIDTH=8 -> latency is 9 cycles and results match the reference model.
